// File: rtl/alu_issue_ctrl_if.sv
// Issue-side and result-side handshake bundle for alu_issue_ctrl.
// master drives instructions and consumes results; slave is the controller.
interface alu_issue_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_opcode;
    logic [15:0] in_src_a;
    logic [15:0] in_src_b;
    logic [15:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic        out_branch_taken;
    logic        out_illegal;

    modport master (
        output in_valid, in_opcode, in_src_a, in_src_b, in_imm,
        output out_ready,
        input  in_ready, out_valid, out_result,
        input  out_branch_taken, out_illegal
    );

    modport slave (
        input  in_valid, in_opcode, in_src_a, in_src_b, in_imm,
        input  out_ready,
        output in_ready, out_valid, out_result,
        output out_branch_taken, out_illegal
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Single-issue ALU controller: latch and decode one instruction,
// drive the external ALU for one cycle, then hold the result until taken.
module alu_issue_ctrl (
    input  logic            clk,
    input  logic            rst_n,
    alu_issue_ctrl_if.slave bus,
    output logic [15:0]     alu_a,
    output logic [15:0]     alu_b,
    output logic [3:0]      alu_op_type,
    output logic            alu_one_zero,
    input  logic [15:0]     alu_result,
    input  logic            alu_zero,
    output logic [15:0]     op_count
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic        accept;
    logic        handshake;
    logic [3:0]  dec_type;
    logic        dec_oz;
    logic        dec_imm;
    logic        dec_ill;
    logic        dec_beq;
    logic        dec_bne;
    logic        is_beq;
    logic        is_bne;
    logic        ill_q;
    logic [15:0] result_q;
    logic        taken_q;
    logic        illegal_q;
    logic [15:0] count_q;

    // in_ready is gated by rst_n so it stays low while reset is held
    assign bus.in_ready         = rst_n & (state_q == IDLE);
    assign bus.out_valid        = (state_q == DONE);
    assign bus.out_result       = result_q;
    assign bus.out_branch_taken = taken_q;
    assign bus.out_illegal      = illegal_q;
    assign op_count             = count_q;

    assign accept    = bus.in_valid & bus.in_ready;
    assign handshake = (state_q == DONE) & bus.out_ready;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = ISSUE;
            ISSUE:   state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dec_type = 4'd6;
        dec_oz   = 1'b0;
        dec_imm  = 1'b0;
        dec_ill  = 1'b0;
        dec_beq  = 1'b0;
        dec_bne  = 1'b0;
        unique case (bus.in_opcode)
            4'd0:  dec_type = 4'd0;
            4'd1:  dec_type = 4'd1;
            4'd2:  dec_type = 4'd2;
            4'd3:  dec_type = 4'd3;
            4'd4:  dec_type = 4'd4;
            4'd5:  dec_type = 4'd5;
            4'd6: begin
                dec_type = 4'd5;
                dec_oz   = 1'b1;
            end
            4'd7: begin
                dec_type = 4'd7;
                dec_imm  = 1'b1;
            end
            4'd8: begin
                dec_type = 4'd8;
                dec_beq  = 1'b1;
            end
            4'd9: begin
                dec_type = 4'd8;
                dec_bne  = 1'b1;
            end
            4'd10:   dec_type = 4'd6;
            default: dec_ill  = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a        <= '0;
            alu_b        <= '0;
            alu_op_type  <= '0;
            alu_one_zero <= 1'b0;
            is_beq       <= 1'b0;
            is_bne       <= 1'b0;
            ill_q        <= 1'b0;
            result_q     <= '0;
            taken_q      <= 1'b0;
            illegal_q    <= 1'b0;
            count_q      <= '0;
        end else begin
            if (accept) begin
                alu_a        <= bus.in_src_a;
                alu_b        <= dec_imm ? bus.in_imm : bus.in_src_b;
                alu_op_type  <= dec_type;
                alu_one_zero <= dec_oz;
                is_beq       <= dec_beq;
                is_bne       <= dec_bne;
                ill_q        <= dec_ill;
            end
            // result side only moves at the closing edge of ISSUE
            if (state_q == ISSUE) begin
                result_q  <= ill_q ? 16'h0000 : alu_result;
                taken_q   <= (is_beq & alu_zero) | (is_bne & ~alu_zero);
                illegal_q <= ill_q;
            end
            if (handshake) count_q <= count_q + 16'd1;
        end
    end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: behavioural ALU plus an opcode-level
// reference model, directed cases and randomized traffic.
module tb_alu_issue_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] alu_a, alu_b, alu_result, op_count;
    logic [3:0]  alu_op_type;
    logic        alu_one_zero, alu_zero;
    int          n_tests = 0;
    int          n_fail = 0;
    logic [15:0] exp_count = 16'h0000;

    always #5 clk = ~clk;

    alu_issue_ctrl_if bus ();

    alu_issue_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_op_type  (alu_op_type),
        .alu_one_zero (alu_one_zero),
        .alu_result   (alu_result),
        .alu_zero     (alu_zero),
        .op_count     (op_count)
    );

    // combinational ALU sitting behind the controller
    always_comb begin
        alu_result = 16'h0000;
        case (alu_op_type)
            4'd0, 4'd7: alu_result = alu_a + alu_b;
            4'd1, 4'd8: alu_result = alu_a - alu_b;
            4'd2: alu_result = alu_a | alu_b;
            4'd3: alu_result = alu_a & alu_b;
            4'd4: alu_result = {15'd0, $signed(alu_a) < $signed(alu_b)};
            4'd5: alu_result = alu_one_zero ? (alu_a >> alu_b[3:0])
                                            : (alu_a << alu_b[3:0]);
            default: alu_result = 16'h0000;
        endcase
    end
    assign alu_zero = (alu_result == 16'h0000);

    typedef struct packed {
        logic [3:0]  ty;
        logic        oz;
        logic [15:0] b;
        logic [15:0] res;
        logic        br;
        logic        ill;
    } exp_t;

    function automatic exp_t model(input logic [3:0] op,
                                   input logic [15:0] a, input logic [15:0] b,
                                   input logic [15:0] imm);
        exp_t e;
        e.ty = 4'd6; e.oz = 1'b0; e.b = b;
        e.res = 16'h0000; e.br = 1'b0; e.ill = 1'b0;
        case (op)
            4'd0: begin e.ty = 4'd0; e.res = a + b; end
            4'd1: begin e.ty = 4'd1; e.res = a - b; end
            4'd2: begin e.ty = 4'd2; e.res = a | b; end
            4'd3: begin e.ty = 4'd3; e.res = a & b; end
            4'd4: begin e.ty = 4'd4; e.res = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0; end
            4'd5: begin e.ty = 4'd5; e.res = a << b[3:0]; end
            4'd6: begin e.ty = 4'd5; e.oz = 1'b1; e.res = a >> b[3:0]; end
            4'd7: begin e.ty = 4'd7; e.b = imm; e.res = a + imm; end
            4'd8: begin e.ty = 4'd8; e.res = a - b; e.br = (a == b); end
            4'd9: begin e.ty = 4'd8; e.res = a - b; e.br = (a != b); end
            4'd10: e.ty = 4'd6;
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    task automatic run_op(input logic [3:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] imm,
                          input int hold, input string tag);
        exp_t e;
        e = model(op, a, b, imm);
        n_tests++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s idle_ready: got %b want 1", tag, bus.in_ready);
        end
        bus.in_valid = 1'b1; bus.in_opcode = op;
        bus.in_src_a = a; bus.in_src_b = b; bus.in_imm = imm;
        bus.out_ready = (hold == 0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        n_tests++;
        if ({alu_a, alu_b, alu_op_type, alu_one_zero, bus.out_valid, bus.in_ready}
            !== {a, e.b, e.ty, e.oz, 2'b00}) begin
            n_fail++;
            $display("FAIL %s issue: got a=%h b=%h ty=%0d oz=%b v=%b r=%b want a=%h b=%h ty=%0d oz=%b v=0 r=0",
                     tag, alu_a, alu_b, alu_op_type, alu_one_zero, bus.out_valid,
                     bus.in_ready, a, e.b, e.ty, e.oz);
        end
        @(negedge clk);
        n_tests++;
        if ({bus.out_valid, bus.out_result, bus.out_branch_taken, bus.out_illegal}
            !== {1'b1, e.res, e.br, e.ill}) begin
            n_fail++;
            $display("FAIL %s done: got v=%b res=%h br=%b ill=%b want v=1 res=%h br=%b ill=%b",
                     tag, bus.out_valid, bus.out_result, bus.out_branch_taken,
                     bus.out_illegal, e.res, e.br, e.ill);
        end
        for (int i = 0; i < hold; i++) begin
            bus.in_valid  = 1'b1;
            bus.in_opcode = 4'($urandom_range(0, 15));
            bus.in_src_a  = 16'($urandom);
            bus.in_src_b  = 16'($urandom);
            @(negedge clk);
            n_tests++;
            if ({bus.out_valid, bus.in_ready, bus.out_result, bus.out_branch_taken,
                 bus.out_illegal, op_count, alu_a, alu_op_type}
                !== {2'b10, e.res, e.br, e.ill, exp_count, a, e.ty}) begin
                n_fail++;
                $display("FAIL %s hold%0d: got v=%b r=%b res=%h br=%b ill=%b cnt=%h a=%h ty=%0d want v=1 r=0 res=%h br=%b ill=%b cnt=%h a=%h ty=%0d",
                         tag, i, bus.out_valid, bus.in_ready, bus.out_result,
                         bus.out_branch_taken, bus.out_illegal, op_count, alu_a,
                         alu_op_type, e.res, e.br, e.ill, exp_count, a, e.ty);
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        exp_count = exp_count + 16'd1;
        n_tests++;
        if ({bus.out_valid, bus.in_ready, op_count, alu_a} !== {2'b01, exp_count, a}) begin
            n_fail++;
            $display("FAIL %s retire: got v=%b r=%b cnt=%h a=%h want v=0 r=1 cnt=%h a=%h",
                     tag, bus.out_valid, bus.in_ready, op_count, alu_a, exp_count, a);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        n_tests++;
        if ({bus.in_ready, bus.out_valid, bus.out_result, bus.out_branch_taken,
             bus.out_illegal, alu_a, alu_b, alu_op_type, alu_one_zero, op_count}
            !== 72'h0) begin
            n_fail++;
            $display("FAIL %s: got r=%b v=%b res=%h br=%b ill=%b a=%h b=%h ty=%h oz=%b cnt=%h want all zero",
                     tag, bus.in_ready, bus.out_valid, bus.out_result,
                     bus.out_branch_taken, bus.out_illegal, alu_a, alu_b,
                     alu_op_type, alu_one_zero, op_count);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.in_opcode = 4'd0;
        bus.in_src_a = 16'h0; bus.in_src_b = 16'h0; bus.in_imm = 16'h0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset_state");
        rst_n = 1'b1;
        exp_count = 16'h0000;
        @(negedge clk);
        n_tests++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b want 1", bus.in_ready);
        end
    endtask

    task automatic test_directed();
        run_op(4'd0,  16'h0003, 16'h0004, 16'h0000, 0, "add");
        run_op(4'd6,  16'h8000, 16'h0004, 16'h0000, 0, "srl");
        run_op(4'd5,  16'h0001, 16'h000F, 16'h0000, 0, "sll");
        run_op(4'd8,  16'h1234, 16'h1234, 16'h0000, 0, "beq_eq");
        run_op(4'd9,  16'h1234, 16'h1234, 16'h0000, 0, "bne_eq");
        run_op(4'd9,  16'h1234, 16'h1235, 16'h0000, 0, "bne_ne");
        run_op(4'd7,  16'h0010, 16'hABCD, 16'hFFFF, 0, "addi");
        run_op(4'd4,  16'hFFFF, 16'h0001, 16'h0000, 0, "slt_neg");
        run_op(4'd10, 16'h5555, 16'hAAAA, 16'h0000, 0, "nop");
    endtask

    task automatic test_hold();
        run_op(4'd1, 16'h0100, 16'h0001, 16'h0000, 5, "hold_sub");
        run_op(4'd2, 16'hF0F0, 16'h0F0F, 16'h0000, 3, "hold_or");
    endtask

    task automatic test_illegal();
        run_op(4'hC, 16'h1111, 16'h2222, 16'h3333, 0, "illegal_c");
        run_op(4'hF, 16'hFFFF, 16'hFFFF, 16'h0000, 1, "illegal_f");
        run_op(4'd3, 16'hFF00, 16'h0FF0, 16'h0000, 0, "and_after_ill");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++)
            run_op(4'(i % 4), 16'($urandom), 16'($urandom), 16'h0, 0, "b2b");
    endtask

    task automatic test_random();
        logic [15:0] a, b;
        for (int i = 0; i < 60; i++) begin
            a = 16'($urandom);
            b = ($urandom_range(0, 3) == 0) ? a : 16'($urandom);
            run_op(4'($urandom_range(0, 15)), a, b, 16'($urandom),
                   $urandom_range(0, 2), "rand");
        end
    endtask

    task automatic test_wrap();
        force dut.count_q = 16'hFFFE;
        #1;
        release dut.count_q;
        exp_count = 16'hFFFE;
        run_op(4'd0, 16'h0001, 16'h0001, 16'h0000, 0, "wrap_to_ffff");
        run_op(4'hC, 16'h0001, 16'h0001, 16'h0000, 0, "wrap_ill_to_0");
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.in_opcode = 4'd1;
        bus.in_src_a = 16'h0005; bus.in_src_b = 16'h0003;
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset_in_issue");
        @(negedge clk);
        rst_n = 1'b1;
        exp_count = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_tests++;
            if ({bus.out_valid, bus.in_ready, op_count} !== {2'b01, exp_count}) begin
                n_fail++;
                $display("FAIL post_reset%0d: got v=%b r=%b cnt=%h want v=0 r=1 cnt=%h",
                         i, bus.out_valid, bus.in_ready, op_count, exp_count);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_illegal();
        test_back_to_back();
        test_random();
        test_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
